// File: rtl/prefix_pkg.sv
// Shared definitions for the prefix-sum kernel and its difference decoder:
// FSM state encoding and default data/address/depth sizes.
package prefix_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_WRITE = 3'd4,
    S_RET   = 3'd5
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 256;

endpackage

// File: rtl/prefix_diff_decoder.sv
// prefix_diff_decoder: reads prefix sums b[0..n-1] from a 1-cycle-latency
// source memory and writes a[i] = b[i] - b[i-1] (b[-1] = 0) to a destination
// memory, returning a[n-1]. Four cycles per element, start/done handshake.
// Optional feature macro PREFIX_DIFF_CKSUM_EN adds a checksum port holding the
// XOR of every word written during the current run.
import prefix_pkg::*;

module prefix_diff_decoder #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [31:0]       n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] return_val,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rd_data,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_addr,
`ifdef PREFIX_DIFF_CKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic [DATA_W-1:0] dst_wr_data
);

  // Counter wide enough to hold DEPTH itself so the i >= n_lat test never wraps.
  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    i_q, i_d;
  logic [CNT_W-1:0]    n_lat_q, n_lat_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   ret_q, ret_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   diff;
`ifdef PREFIX_DIFF_CKSUM_EN
  logic [DATA_W-1:0]   cksum_q, cksum_d;
`endif

  // Next-state and registered-strobe logic; strobes are set on the edge that
  // enters READ/WRITE so they are high for exactly that one state.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    n_lat_d   = n_lat_q;
    prev_d    = prev_q;
    last_d    = last_q;
    ret_d     = ret_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    diff      = src_rd_data - prev_q;
`ifdef PREFIX_DIFF_CKSUM_EN
    cksum_d   = cksum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_lat_d = (n > 32'(DEPTH)) ? CNT_W'(DEPTH) : CNT_W'(n);
          i_d     = '0;
          prev_d  = '0;
          last_d  = '0;
`ifdef PREFIX_DIFF_CKSUM_EN
          cksum_d = '0;
`endif
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (i_q >= n_lat_q) begin
          state_d = S_RET;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = ADDR_W'(i_q);
          state_d   = S_READ;
        end
      end
      S_READ: state_d = S_WAIT;
      // Read data is valid in WAIT; the difference is formed here and
      // registered straight onto the write port for the WRITE cycle.
      S_WAIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ADDR_W'(i_q);
        wr_data_d = diff;
        prev_d    = src_rd_data;
        last_d    = diff;
`ifdef PREFIX_DIFF_CKSUM_EN
        cksum_d   = cksum_q ^ diff;
`endif
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        i_d     = i_q + 1'b1;
        state_d = S_CHECK;
      end
      S_RET: begin
        ret_d   = last_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any run in progress at once.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      n_lat_q   <= '0;
      prev_q    <= '0;
      last_q    <= '0;
      ret_q     <= '0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef PREFIX_DIFF_CKSUM_EN
      cksum_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      n_lat_q   <= n_lat_d;
      prev_q    <= prev_d;
      last_q    <= last_d;
      ret_q     <= ret_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef PREFIX_DIFF_CKSUM_EN
      cksum_q   <= cksum_d;
`endif
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign return_val  = ret_q;
  assign src_rd_en   = rd_en_q;
  assign src_addr    = rd_addr_q;
  assign dst_wr_en   = wr_en_q;
  assign dst_addr    = wr_addr_q;
  assign dst_wr_data = wr_data_q;
`ifdef PREFIX_DIFF_CKSUM_EN
  assign checksum    = cksum_q;
`endif

endmodule

// File: tb/tb_prefix_diff_decoder.sv
// Testbench for prefix_diff_decoder: directed and random runs against a
// reference model that computes a[i] = b[i] - b[i-1] over the clamped count.
module tb_prefix_diff_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] n;
  logic        busy, done;
  logic [31:0] return_val;
  logic        src_rd_en;
  logic [7:0]  src_addr;
  logic [31:0] src_rd_data;
  logic        dst_wr_en;
  logic [7:0]  dst_addr;
  logic [31:0] dst_wr_data;
`ifdef PREFIX_DIFF_CKSUM_EN
  logic [31:0] checksum;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] bmem [256];
  logic [7:0]  wa_q [$];
  logic [31:0] wd_q [$];
  int          rd_cnt = 0;
  int          both_cnt = 0;

  prefix_diff_decoder dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .start       (start),
    .n           (n),
    .busy        (busy),
    .done        (done),
    .return_val  (return_val),
    .src_rd_en   (src_rd_en),
    .src_addr    (src_addr),
    .src_rd_data (src_rd_data),
    .dst_wr_en   (dst_wr_en),
    .dst_addr    (dst_addr),
`ifdef PREFIX_DIFF_CKSUM_EN
    .checksum    (checksum),
`endif
    .dst_wr_data (dst_wr_data)
  );

  always #5 clk = ~clk;

  // Source memory with one cycle of read latency.
  always @(posedge clk) begin
    if (src_rd_en) src_rd_data <= bmem[src_addr];
  end

  // Record every access the DUT makes.
  always @(posedge clk) begin
    if (dst_wr_en) begin
      wa_q.push_back(dst_addr);
      wd_q.push_back(dst_wr_data);
    end
    if (src_rd_en) rd_cnt++;
    if (src_rd_en && dst_wr_en) both_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    rd_cnt = 0;
  endtask

  // One full run; the model derives expectations from bmem and the count.
  task automatic run_txn(input int nn, input bit repulse);
    int          nl, cyc, werr;
    logic [31:0] a [256];
    logic [31:0] exp_ret, exp_ck;
    nl = (nn > 256) ? 256 : nn;
    exp_ret = 32'd0;
    exp_ck  = 32'd0;
    for (int k = 0; k < nl; k++) begin
      a[k]   = bmem[k] - ((k == 0) ? 32'd0 : bmem[k-1]);
      exp_ck = exp_ck ^ a[k];
    end
    if (nl > 0) exp_ret = a[nl-1];
    clear_log();
    n     = 32'(nn);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n     = $urandom;
    cyc   = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) chk("busy_run", busy, 1);
      if (repulse && cyc == 6) start = 1'b1;
      if (repulse && cyc == 7) start = 1'b0;
      if (done) break;
    end
    chk("latency", cyc, 4 * nl + 2);
    chk("return_val", return_val, exp_ret);
    chk("wr_count", wa_q.size(), nl);
    chk("rd_count", rd_cnt, nl);
    werr = 0;
    for (int k = 0; k < wa_q.size(); k++) begin
      if (k >= nl) werr++;
      else if (wa_q[k] !== k[7:0] || wd_q[k] !== a[k]) werr++;
    end
    chk("wr_data", werr, 0);
    chk("strobe_overlap", both_cnt, 0);
`ifdef PREFIX_DIFF_CKSUM_EN
    chk("checksum", checksum, exp_ck);
`endif
    $display("txn n=%0d n_lat=%0d ret=%08h cycles=%0d writes=%0d cksum_model=%08h",
             nn, nl, return_val, cyc, wa_q.size(), exp_ck);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    n     = 32'd0;
    for (int k = 0; k < 256; k++) bmem[k] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ret", return_val, 0);
    chk("rst_rd_en", src_rd_en, 0);
    chk("rst_wr_en", dst_wr_en, 0);
    chk("rst_wr_data", dst_wr_data, 0);
`ifdef PREFIX_DIFF_CKSUM_EN
    chk("rst_cksum", checksum, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: simple sums, then n=0.
    bmem[0] = 32'd1; bmem[1] = 32'd3; bmem[2] = 32'd6; bmem[3] = 32'd10;
    run_txn(4, 1'b0);
    run_txn(0, 1'b0);
    // Wrapping subtraction.
    bmem[0] = 32'd5; bmem[1] = 32'd2;
    run_txn(2, 1'b0);
    // Count above depth is clamped.
    for (int k = 0; k < 256; k++) bmem[k] = $urandom;
    run_txn(300, 1'b0);
    // Start re-pulsed while busy must be ignored.
    run_txn(5, 1'b1);

    // Random runs, issued back to back (start lands in the done cycle).
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 256; k++) bmem[k] = $urandom;
      run_txn(int'($urandom_range(0, 20)), t[0]);
    end

    // Reset during WAIT of the second element aborts the run.
    clear_log();
    n     = 32'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_writes", wa_q.size(), 1);
    chk("abort_done", done, 0);
    chk("abort_ret", return_val, 0);
    $display("txn abort n=4 writes=%0d busy=%0d", wa_q.size(), busy);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery after abort.
    bmem[0] = 32'd1; bmem[1] = 32'd3; bmem[2] = 32'd6; bmem[3] = 32'd10;
    run_txn(4, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
